ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage CPU pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its id_* outputs.
- Contains the combinational ALU, signed-overflow detection and exception merging.
- Ends in the EX/MEM pipeline register (ex_*) that feeds the MEM stage.
- Exports the raw ALU result as fwd_data for forwarding to ID.

Parameters:
- none. All widths come from the shared CPU package: word data 32, word address 30, register address 5, ALU op 4, mem op 2, ctrl op 2, exception code 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM register
- flush  in  1  clear EX/MEM register to bubble
- int_detect  in  1  external interrupt taken this cycle
- id_pc  in  30  PC of instruction in EX
- id_en  in  1  instruction valid
- id_alu_op  in  4  ALU operation
- id_alu_in_0  in  32  operand A
- id_alu_in_1  in  32  operand B
- id_br_flag  in  1  branch flag
- id_mem_op  in  2  memory op
- id_mem_wr_data  in  32  store data
- id_ctrl_op  in  2  control op
- id_dst_addr  in  5  destination GPR
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  exception from ID
- fwd_data  out  32  combinational ALU result
- ex_pc  out  30  registered PC
- ex_en  out  1  registered valid
- ex_br_flag  out  1  registered branch flag
- ex_mem_op  out  2  registered memory op
- ex_mem_wr_data  out  32  registered store data
- ex_ctrl_op  out  2  registered control op
- ex_dst_addr  out  5  registered destination
- ex_gpr_we_  out  1  registered GPR write enable, active-low
- ex_exp_code  out  3  registered exception code
- ex_out  out  32  registered ALU result

Behaviour:

ALU (combinational):
- NOP=0: out = A
- AND=1, OR=2, XOR=3: bitwise
- ADDS=4, ADDU=5: A+B, mod 2^32
- SUBS=6, SUBU=7: A-B, mod 2^32
- SHRL=8: A >> B[4:0], logical
- SHLL=9: A << B[4:0]
- codes 10-15: out = 0
- Overflow, ADDS only: A[31]==B[31] and out[31]!=A[31].
- Overflow, SUBS only: A[31]!=B[31] and out[31]!=A[31].
- ovf is never raised for unsigned ops.
- fwd_data = ALU out, zero latency.

Register update (rising clk, priority top-down):
1. reset=1: all ex_* cleared (below).
2. stall=1: all ex_* hold; flush and int_detect are ignored.
3. flush=1: bubble.
4. int_detect=1:
   - ex_pc, ex_en, ex_br_flag, ex_dst_addr, ex_out loaded from inputs.
   - ex_mem_op=NOP, ex_ctrl_op=NOP, ex_gpr_we_=1.
   - ex_exp_code=EXT_INT(1).
5. id_exp_code != NO_EXP: same as step 4, but ex_exp_code=id_exp_code.
6. id_en=1 and ovf=1: same as step 4, but ex_exp_code=OVERFLOW(3). The result is not written back.
7. Otherwise: all ex_* loaded from id_* / ALU out.

Reset and bubble values:
- ex_pc=0, ex_en=0, ex_br_flag=0
- ex_mem_op=NOP(0), ex_mem_wr_data=0, ex_ctrl_op=NOP(0)
- ex_dst_addr=0, ex_gpr_we_=1, ex_exp_code=NO_EXP(0), ex_out=0

Timing and edge cases:
- Latency: one cycle from id_* to ex_*.
- Reset is synchronous. Asserting it mid-stall still clears all ex_* at the next edge.
- A bubble input (id_en=0) passes through unchanged. Overflow is suppressed for it.
- The exception codes above must match the ID stage encoding: EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6.

Decomposition:
- Shared CPU package holds:
  - ALU_OP_* and MEM_OP_* encodings
  - CTRL_OP_* and ISA_EXP_* encodings
  - width constants
  - ENABLE/DISABLE and active-low DISABLE_ levels
- One sub-module: ex_alu, purely combinational, outputs {out, ovf}.
- ex_stage instantiates ex_alu plus the EX/MEM register logic.

Test Plan:
- ADDU A=0xFFFFFFFF, B=1, id_en=1 -> fwd_data=0 same cycle; next edge ex_out=0, ex_exp_code=0, ex_gpr_we_ follows input.
- ADDS A=0x7FFFFFFF, B=1, id_gpr_we_=0, id_mem_op=LDW -> ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=0, ex_out=0x80000000.
- SHRL A=0x80000000, B=0x21 -> out=0x40000000 (shift of 1). SHLL A=1, B=31 -> 0x80000000.
- stall=1 with flush=1 and int_detect=1 for 3 cycles -> ex_* unchanged. Release with flush=1 -> bubble values next edge.
- int_detect=1 with id_exp_code=2 and ADDS overflow -> ex_exp_code=1, ex_pc=id_pc.
- reset=1 mid-stream on a clock edge -> all outputs at reset values that edge. Deassert -> normal capture resumes next edge.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared CPU package: width constants, logic levels and the ALU, memory,
// control and exception encodings used across the pipeline stages.
// Exception codes must stay in step with the ID stage encoding.
package ex_stage_pkg;

   // Width constants
   localparam int WORD_DATA_W = 32;
   localparam int WORD_ADDR_W = 30;
   localparam int REG_ADDR_W  = 5;
   localparam int ALU_OP_W    = 4;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;
   localparam int ISA_EXP_W   = 3;

   // Logic levels
   localparam logic ENABLE   = 1'b1;
   localparam logic DISABLE  = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // ALU operations
   localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADDS = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUBS = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SHRL = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'd9;

   // Memory operations
   localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;
   localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 2'd1;
   localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 2'd2;

   // Control operations
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP  = 2'd0;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_WRCR = 2'd1;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_EXRT = 2'd2;

   // Exception codes
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT    = 3'd1;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_TRAP       = 3'd5;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_PRV_VIO    = 3'd6;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage: result plus signed overflow.
// Zero latency; no state.
// Overflow is reported only for the signed add/subtract operations.
import ex_stage_pkg::*;

module ex_alu (
   input  logic [ALU_OP_W-1:0]    op,
   input  logic [WORD_DATA_W-1:0] in_0,
   input  logic [WORD_DATA_W-1:0] in_1,
   output logic [WORD_DATA_W-1:0] out,
   output logic                   ovf
);

   // Operation select and overflow detection from operand/result sign bits
   always_comb begin
      out = '0;
      ovf = DISABLE;
      case (op)
         ALU_OP_NOP:  out = in_0;
         ALU_OP_AND:  out = in_0 & in_1;
         ALU_OP_OR:   out = in_0 | in_1;
         ALU_OP_XOR:  out = in_0 ^ in_1;
         ALU_OP_ADDS: begin
            out = in_0 + in_1;
            ovf = (in_0[31] == in_1[31]) && (out[31] != in_0[31]);
         end
         ALU_OP_ADDU: out = in_0 + in_1;
         ALU_OP_SUBS: begin
            out = in_0 - in_1;
            ovf = (in_0[31] != in_1[31]) && (out[31] != in_0[31]);
         end
         ALU_OP_SUBU: out = in_0 - in_1;
         ALU_OP_SHRL: out = in_0 >> in_1[4:0];
         ALU_OP_SHLL: out = in_0 << in_1[4:0];
         default:     out = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, exception merging and the EX/MEM pipeline register.
// One cycle from id_* to ex_*; fwd_data is the raw ALU result, zero latency.
// stall holds the register (dominates flush/interrupt); flush inserts a bubble.
import ex_stage_pkg::*;

module ex_stage (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   int_detect,
   input  logic [WORD_ADDR_W-1:0] id_pc,
   input  logic                   id_en,
   input  logic [ALU_OP_W-1:0]    id_alu_op,
   input  logic [WORD_DATA_W-1:0] id_alu_in_0,
   input  logic [WORD_DATA_W-1:0] id_alu_in_1,
   input  logic                   id_br_flag,
   input  logic [MEM_OP_W-1:0]    id_mem_op,
   input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
   input  logic [CTRL_OP_W-1:0]   id_ctrl_op,
   input  logic [REG_ADDR_W-1:0]  id_dst_addr,
   input  logic                   id_gpr_we_,
   input  logic [ISA_EXP_W-1:0]   id_exp_code,
   output logic [WORD_DATA_W-1:0] fwd_data,
   output logic [WORD_ADDR_W-1:0] ex_pc,
   output logic                   ex_en,
   output logic                   ex_br_flag,
   output logic [MEM_OP_W-1:0]    ex_mem_op,
   output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
   output logic [CTRL_OP_W-1:0]   ex_ctrl_op,
   output logic [REG_ADDR_W-1:0]  ex_dst_addr,
   output logic                   ex_gpr_we_,
   output logic [ISA_EXP_W-1:0]   ex_exp_code,
   output logic [WORD_DATA_W-1:0] ex_out
);

   logic [WORD_DATA_W-1:0] alu_out;
   logic                   alu_ovf;

   ex_alu u_alu (
      .op   (id_alu_op),
      .in_0 (id_alu_in_0),
      .in_1 (id_alu_in_1),
      .out  (alu_out),
      .ovf  (alu_ovf)
   );

   assign fwd_data = alu_out;

   // EX/MEM register: reset, stall, flush, then exception merge by priority
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_pc          <= '0;
         ex_en          <= DISABLE;
         ex_br_flag     <= DISABLE;
         ex_mem_op      <= MEM_OP_NOP;
         ex_mem_wr_data <= '0;
         ex_ctrl_op     <= CTRL_OP_NOP;
         ex_dst_addr    <= '0;
         ex_gpr_we_     <= DISABLE_;
         ex_exp_code    <= ISA_EXP_NO_EXP;
         ex_out         <= '0;
      end else if (!stall) begin
         if (flush) begin
            ex_pc          <= '0;
            ex_en          <= DISABLE;
            ex_br_flag     <= DISABLE;
            ex_mem_op      <= MEM_OP_NOP;
            ex_mem_wr_data <= '0;
            ex_ctrl_op     <= CTRL_OP_NOP;
            ex_dst_addr    <= '0;
            ex_gpr_we_     <= DISABLE_;
            ex_exp_code    <= ISA_EXP_NO_EXP;
            ex_out         <= '0;
         end else begin
            // Fields carried through regardless of exception
            ex_pc          <= id_pc;
            ex_en          <= id_en;
            ex_br_flag     <= id_br_flag;
            ex_mem_wr_data <= id_mem_wr_data;
            ex_dst_addr    <= id_dst_addr;
            ex_out         <= alu_out;
            if (int_detect || (id_exp_code != ISA_EXP_NO_EXP) || (id_en && alu_ovf)) begin
               // Excepting instruction: kill its memory, control and writeback effects
               ex_mem_op  <= MEM_OP_NOP;
               ex_ctrl_op <= CTRL_OP_NOP;
               ex_gpr_we_ <= DISABLE_;
               if (int_detect)
                  ex_exp_code <= ISA_EXP_EXT_INT;
               else if (id_exp_code != ISA_EXP_NO_EXP)
                  ex_exp_code <= id_exp_code;
               else
                  ex_exp_code <= ISA_EXP_OVERFLOW;
            end else begin
               ex_mem_op   <= id_mem_op;
               ex_ctrl_op  <= id_ctrl_op;
               ex_gpr_we_  <= id_gpr_we_;
               ex_exp_code <= ISA_EXP_NO_EXP;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Inputs change #1 after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
import ex_stage_pkg::*;

module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, int_detect;
   logic [29:0] id_pc;
   logic        id_en;
   logic [3:0]  id_alu_op;
   logic [31:0] id_alu_in_0, id_alu_in_1;
   logic        id_br_flag;
   logic [1:0]  id_mem_op;
   logic [31:0] id_mem_wr_data;
   logic [1:0]  id_ctrl_op;
   logic [4:0]  id_dst_addr;
   logic        id_gpr_we_;
   logic [2:0]  id_exp_code;
   logic [31:0] fwd_data;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [1:0]  ex_ctrl_op;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;
   logic [31:0] ex_out;

   int errors = 0;
   int checks = 0;

   ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
      .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
      .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
      .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
      .id_exp_code(id_exp_code), .fwd_data(fwd_data),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      id_alu_op   = op;
      id_alu_in_0 = a;
      id_alu_in_1 = b;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".pc"},   32'(ex_pc), 32'h0);
      check({tag, ".en"},   32'(ex_en), 32'h0);
      check({tag, ".mop"},  32'(ex_mem_op), 32'h0);
      check({tag, ".wdat"}, ex_mem_wr_data, 32'h0);
      check({tag, ".dst"},  32'(ex_dst_addr), 32'h0);
      check({tag, ".we_"},  32'(ex_gpr_we_), 32'h1);
      check({tag, ".exp"},  32'(ex_exp_code), 32'h0);
      check({tag, ".out"},  ex_out, 32'h0);
   endtask

   initial begin
      reset = 1; stall = 0; flush = 0; int_detect = 0;
      id_pc = 30'h0; id_en = 0; id_br_flag = 0; id_mem_op = 0; id_mem_wr_data = 0;
      id_ctrl_op = 0; id_dst_addr = 0; id_gpr_we_ = 1; id_exp_code = 0;
      set_alu(4'd0, 32'h0, 32'h0);
      step(); step();
      check_bubble("reset");
      reset = 0;

      // ADDU wrap: fwd_data same cycle, clean capture next edge
      id_pc = 30'h100; id_en = 1; id_gpr_we_ = 0; id_dst_addr = 5'd7; id_br_flag = 1;
      id_mem_wr_data = 32'hCAFE0001;
      set_alu(ALU_OP_ADDU, 32'hFFFFFFFF, 32'h1);
      #1 check("addu.fwd", fwd_data, 32'h0);
      step();
      check("addu.out", ex_out, 32'h0);
      check("addu.exp", 32'(ex_exp_code), 32'h0);
      check("addu.we_", 32'(ex_gpr_we_), 32'h0);
      check("addu.pc",  32'(ex_pc), 32'h100);
      check("addu.en",  32'(ex_en), 32'h1);
      check("addu.dst", 32'(ex_dst_addr), 32'h7);
      check("addu.br",  32'(ex_br_flag), 32'h1);
      check("addu.wdat", ex_mem_wr_data, 32'hCAFE0001);

      // ADDS overflow: writeback and memory op suppressed
      id_br_flag = 0; id_mem_op = MEM_OP_LDW; id_ctrl_op = CTRL_OP_WRCR;
      set_alu(ALU_OP_ADDS, 32'h7FFFFFFF, 32'h1);
      #1 check("adds.fwd", fwd_data, 32'h80000000);
      step();
      check("adds.exp", 32'(ex_exp_code), 32'h3);
      check("adds.we_", 32'(ex_gpr_we_), 32'h1);
      check("adds.mop", 32'(ex_mem_op), 32'h0);
      check("adds.cop", 32'(ex_ctrl_op), 32'h0);
      check("adds.out", ex_out, 32'h80000000);

      // Normal capture of memory/control ops
      set_alu(ALU_OP_SUBS, 32'h5, 32'h7);
      step();
      check("subs.out", ex_out, 32'hFFFFFFFE);
      check("subs.exp", 32'(ex_exp_code), 32'h0);
      check("subs.mop", 32'(ex_mem_op), 32'h1);
      check("subs.cop", 32'(ex_ctrl_op), 32'h1);
      id_mem_op = 0; id_ctrl_op = 0;

      // SUBS overflow: negative minus positive crossing to positive
      set_alu(ALU_OP_SUBS, 32'h80000000, 32'h1);
      step();
      check("subs_ovf.exp", 32'(ex_exp_code), 32'h3);
      check("subs_ovf.out", ex_out, 32'h7FFFFFFF);

      // Unsigned sub never overflows
      set_alu(ALU_OP_SUBU, 32'h80000000, 32'h1);
      step();
      check("subu.exp", 32'(ex_exp_code), 32'h0);

      // Bubble input: overflow suppressed, fields pass through
      id_en = 0;
      set_alu(ALU_OP_ADDS, 32'h7FFFFFFF, 32'h1);
      step();
      check("bub.exp", 32'(ex_exp_code), 32'h0);
      check("bub.en",  32'(ex_en), 32'h0);
      check("bub.we_", 32'(ex_gpr_we_), 32'h0);
      check("bub.out", ex_out, 32'h80000000);
      id_en = 1;

      // Combinational ALU patterns
      set_alu(ALU_OP_SHRL, 32'h80000000, 32'h21); #1 check("shrl", fwd_data, 32'h40000000);
      set_alu(ALU_OP_SHLL, 32'h1, 32'd31);        #1 check("shll", fwd_data, 32'h80000000);
      set_alu(ALU_OP_AND, 32'hF0F0FF00, 32'hFF00F0F0); #1 check("and", fwd_data, 32'hF000F000);
      set_alu(ALU_OP_OR,  32'hF0F0FF00, 32'hFF00F0F0); #1 check("or",  fwd_data, 32'hFFF0FFF0);
      set_alu(ALU_OP_XOR, 32'hF0F0FF00, 32'hFF00F0F0); #1 check("xor", fwd_data, 32'h0FF00FF0);
      set_alu(ALU_OP_NOP, 32'h12345678, 32'hFFFFFFFF); #1 check("nop", fwd_data, 32'h12345678);
      set_alu(4'd12, 32'h12345678, 32'h1);              #1 check("op12", fwd_data, 32'h0);

      // Stall holds even with flush and interrupt requested
      id_pc = 30'h200; set_alu(ALU_OP_ADDU, 32'd2, 32'd3);
      step();
      check("pre_stall.out", ex_out, 32'd5);
      stall = 1; flush = 1; int_detect = 1;
      id_pc = 30'h300; set_alu(ALU_OP_ADDU, 32'd9, 32'd9);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall.out", ex_out, 32'd5);
         check("stall.pc",  32'(ex_pc), 32'h200);
         check("stall.exp", 32'(ex_exp_code), 32'h0);
      end
      stall = 0; int_detect = 0;
      step();
      check_bubble("flush");
      flush = 0;

      // Interrupt outranks ID exception and overflow
      int_detect = 1; id_exp_code = ISA_EXP_UNDEF_INSN; id_pc = 30'h1234;
      set_alu(ALU_OP_ADDS, 32'h7FFFFFFF, 32'h1);
      step();
      check("int.exp", 32'(ex_exp_code), 32'h1);
      check("int.pc",  32'(ex_pc), 32'h1234);
      check("int.we_", 32'(ex_gpr_we_), 32'h1);
      int_detect = 0;
      step();
      check("idexp.exp", 32'(ex_exp_code), 32'h2);
      id_exp_code = 0;

      // Reset mid-stream, asserted during stall
      set_alu(ALU_OP_ADDU, 32'd10, 32'd20); id_pc = 30'h40;
      step();
      check("pre_rst.out", ex_out, 32'd30);
      reset = 1; stall = 1;
      step();
      check_bubble("rst_mid");
      reset = 0; stall = 0;
      step();
      check("post_rst.out", ex_out, 32'd30);
      check("post_rst.pc",  32'(ex_pc), 32'h40);
      check("post_rst.en",  32'(ex_en), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
